// File: rtl/hamming74_pkg.sv
// Hamming(7,4) constants and SEC helpers.
// The encoder and decoder sides share these.
package hamming74_pkg;

    localparam int unsigned CW_W   = 7;
    localparam int unsigned DATA_W = 4;

    // Syndrome bit k covers the codeword positions whose 1-based index has bit k set.
    function automatic logic [2:0] ham74_syndrome(input logic [CW_W-1:0] cw);
        logic s0, s1, s2;
        s0 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s1 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s2 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return {s2, s1, s0};
    endfunction

    function automatic logic [CW_W-1:0] ham74_correct(input logic [CW_W-1:0] cw,
                                                      input logic [2:0]      syn);
        logic [CW_W-1:0] fixed;
        fixed = cw;
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
        end
        return fixed;
    endfunction

    function automatic logic [DATA_W-1:0] ham74_data(input logic [CW_W-1:0] cw);
        return {cw[6], cw[5], cw[4], cw[2]};
    endfunction

endpackage

// File: rtl/hamming74_sync_fifo.sv
// Show-ahead synchronous FIFO.
// The full and empty flags are registered.
module hamming74_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_wr, do_rd})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
        end
    end

    // Storage is cleared on reset so the show-ahead output reads zero while empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/hamming74_rx_assembler.sv
// Hamming(7,4) receive front end: serial-to-codeword, SEC correction, nibble pairing,
// byte FIFO and saturating link-quality counters.
module hamming74_rx_assembler #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             frame_sync,
    input  logic             clear_counts,
    output logic [7:0]       byte_out,
    output logic             byte_err,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [CNT_W-1:0] cw_count,
    output logic [CNT_W-1:0] corr_count
);

    import hamming74_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [2:0]        bit_cnt;
    logic [CW_W-2:0]   sr;
    logic              nib_phase;
    logic [DATA_W-1:0] lo_nib;
    logic              lo_err;

    logic              accept;
    logic              complete;
    logic              push;
    logic              pop;
    logic [CW_W-1:0]   cw;
    logic [2:0]        syn;
    logic [DATA_W-1:0] nib;
    logic              cw_err;
    logic              fifo_full;
    logic              fifo_empty;
    logic [8:0]        fifo_rd;

    assign accept     = bit_valid && bit_ready;
    // A bit arriving together with frame_sync is dropped, so it can never complete a codeword.
    assign complete   = accept && !frame_sync && (bit_cnt == 3'd6);
    assign push       = complete && nib_phase;
    assign pop        = byte_valid && byte_ready;
    assign bit_ready  = !fifo_full;
    assign byte_valid = !fifo_empty;
    assign byte_err   = fifo_rd[8];
    assign byte_out   = fifo_rd[7:0];

    always_comb begin
        cw     = {bit_in, sr};
        syn    = ham74_syndrome(cw);
        nib    = ham74_data(ham74_correct(cw, syn));
        cw_err = (syn != 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            sr        <= '0;
            nib_phase <= 1'b0;
            lo_nib    <= '0;
            lo_err    <= 1'b0;
        end else if (frame_sync) begin
            bit_cnt   <= '0;
            nib_phase <= 1'b0;
        end else if (accept) begin
            if (bit_cnt == 3'd6) begin
                bit_cnt   <= '0;
                nib_phase <= !nib_phase;
                if (!nib_phase) begin
                    lo_nib <= nib;
                    lo_err <= cw_err;
                end
            end else begin
                sr[bit_cnt] <= bit_in;
                bit_cnt     <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_count   <= '0;
            corr_count <= '0;
        end else if (clear_counts) begin
            cw_count   <= '0;
            corr_count <= '0;
        end else if (complete) begin
            if (cw_count != '1) begin
                cw_count <= cw_count + CNT_ONE;
            end
            if (cw_err && (corr_count != '1)) begin
                corr_count <= corr_count + CNT_ONE;
            end
        end
    end

    hamming74_sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({lo_err | cw_err, nib, lo_nib}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_hamming74_rx_assembler.sv
// Directed self-checking bench for hamming74_rx_assembler (CNT_W=4, FIFO_DEPTH=4).
module tb_hamming74_rx_assembler;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       frame_sync;
    logic       clear_counts;
    logic [7:0] byte_out;
    logic       byte_err;
    logic       byte_valid;
    logic       byte_ready;
    logic [3:0] cw_count;
    logic [3:0] corr_count;

    int checks   = 0;
    int failures = 0;

    hamming74_rx_assembler #(
        .CNT_W      (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .frame_sync   (frame_sync),
        .clear_counts (clear_counts),
        .byte_out     (byte_out),
        .byte_err     (byte_err),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .cw_count     (cw_count),
        .corr_count   (corr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: cw = {d3,d2,d1,p4,d0,p2,p1}
    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    task automatic send_bit(input logic b, input logic sync, input logic clr);
        int unsigned waited;
        waited = 0;
        while (!bit_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bit_ready) check("bit_ready_timeout", 32'(bit_ready), 1);
        bit_in       = b;
        bit_valid    = 1'b1;
        frame_sync   = sync;
        clear_counts = clr;
        @(posedge clk);
        #1;
        bit_valid    = 1'b0;
        frame_sync   = 1'b0;
        clear_counts = 1'b0;
    endtask

    task automatic send_bits(input logic [6:0] cw, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_bit(cw[i], 1'b0, 1'b0);
    endtask

    task automatic send_cw(input logic [6:0] cw);
        send_bits(cw, 7);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_cw(enc(b[3:0]));
        send_cw(enc(b[7:4]));
    endtask

    task automatic clear_pulse();
        clear_counts = 1'b1;
        @(posedge clk);
        #1;
        clear_counts = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp_byte, input logic exp_err);
        check({tag, "_valid"}, 32'(byte_valid), 1);
        check({tag, "_byte"}, 32'(byte_out), 32'(exp_byte));
        check({tag, "_err"}, 32'(byte_err), 32'(exp_err));
        byte_ready = 1'b1;
        @(posedge clk);
        #1;
        byte_ready = 1'b0;
    endtask

    initial begin
        logic [6:0] v;
        rst          = 1'b1;
        bit_in       = 1'b0;
        bit_valid    = 1'b0;
        frame_sync   = 1'b0;
        clear_counts = 1'b0;
        byte_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_byte_out", 32'(byte_out), 0);
        check("rst_byte_err", 32'(byte_err), 0);
        check("rst_cw_count", 32'(cw_count), 0);
        check("rst_corr_count", 32'(corr_count), 0);
        check("rst_bit_ready", 32'(bit_ready), 1);
        rst = 1'b0;

        // Reset mid-stream: one buffered byte plus 10 bits are lost
        send_cw(7'h2D);
        send_cw(7'h52);
        send_cw(7'h2D);
        send_bits(7'h52, 3);
        check("pre_rst_valid", 32'(byte_valid), 1);
        check("pre_rst_cw", 32'(cw_count), 3);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(byte_valid), 0);
        check("mid_rst_cw", 32'(cw_count), 0);
        check("mid_rst_corr", 32'(corr_count), 0);
        check("mid_rst_ready", 32'(bit_ready), 1);
        check("mid_rst_byte", 32'(byte_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_cw(7'h2D);
        send_cw(7'h52);
        check("post_rst_cw", 32'(cw_count), 2);
        pop_check("post_rst", 8'hA5, 1'b0);
        check("post_rst_one_byte", 32'(byte_valid), 0);

        // Clean data with byte_ready held high; latency check around the 14th bit
        clear_pulse();
        check("clear_cw", 32'(cw_count), 0);
        byte_ready = 1'b1;
        send_cw(7'h2D);
        send_bits(7'h52, 6);
        check("clean_13_valid", 32'(byte_valid), 0);
        send_bit(1'b1, 1'b0, 1'b0);
        check("clean_valid", 32'(byte_valid), 1);
        check("clean_byte", 32'(byte_out), 'hA5);
        check("clean_err", 32'(byte_err), 0);
        check("clean_cw", 32'(cw_count), 2);
        check("clean_corr", 32'(corr_count), 0);
        @(posedge clk);
        #1;
        check("clean_drained", 32'(byte_valid), 0);
        byte_ready = 1'b0;

        // Single-bit error at each position of the low codeword
        for (int unsigned p = 0; p < 7; p++) begin
            clear_pulse();
            v = 7'h2D ^ (7'd1 << p);
            send_cw(v);
            send_cw(7'h52);
            check($sformatf("err_pos%0d_corr", p + 1), 32'(corr_count), 1);
            check($sformatf("err_pos%0d_cw", p + 1), 32'(cw_count), 2);
            pop_check($sformatf("err_pos%0d", p + 1), 8'hA5, 1'b1);
        end
        v = 7'h52 ^ 7'h20;
        send_cw(7'h2D);
        send_cw(v);
        pop_check("err_hi", 8'hA5, 1'b1);

        // Backpressure: fill FIFO, hold a pending bit, then drain in order
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("bp_full_ready", 32'(bit_ready), 0);
        v = enc(4'h5);
        bit_in    = v[0];
        bit_valid = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("bp_stall_ready", 32'(bit_ready), 0);
            check("bp_stall_byte", 32'(byte_out), 'h11);
        end
        pop_check("bp_0", 8'h11, 1'b0);
        check("bp_ready_back", 32'(bit_ready), 1);
        send_byte(8'h55);
        check("bp_full_again", 32'(bit_ready), 0);
        pop_check("bp_1", 8'h22, 1'b0);
        pop_check("bp_2", 8'h33, 1'b0);
        pop_check("bp_3", 8'h44, 1'b0);
        pop_check("bp_4", 8'h55, 1'b0);
        check("bp_empty", 32'(byte_valid), 0);

        // frame_sync after 10 bits, with the 11th bit in the same cycle
        clear_pulse();
        send_cw(7'h52);
        send_bits(7'h2D, 3);
        send_bit(1'b1, 1'b1, 1'b0);
        check("sync_cw", 32'(cw_count), 1);
        check("sync_valid", 32'(byte_valid), 0);
        send_cw(7'h2D);
        send_cw(7'h52);
        check("sync_after_cw", 32'(cw_count), 3);
        pop_check("sync_after", 8'hA5, 1'b0);
        // frame_sync on what would be the completing bit
        send_bits(7'h2D, 6);
        send_bit(1'b0, 1'b1, 1'b0);
        check("sync7_cw", 32'(cw_count), 3);
        send_cw(7'h2D);
        send_cw(7'h52);
        pop_check("sync7_after", 8'hA5, 1'b0);

        // Saturation with 4-bit counters, then clear colliding with a completion
        clear_pulse();
        byte_ready = 1'b1;
        for (int unsigned k = 0; k < 20; k++) send_cw(7'h3D);
        check("sat_corr", 32'(corr_count), 15);
        check("sat_cw", 32'(cw_count), 15);
        send_bits(7'h3D, 6);
        send_bit(1'b0, 1'b0, 1'b1);
        check("clr_cw", 32'(cw_count), 0);
        check("clr_corr", 32'(corr_count), 0);
        send_cw(7'h52);
        check("clr_then_cw", 32'(cw_count), 1);
        check("clr_then_corr", 32'(corr_count), 0);
        byte_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
